sd_data_rx: RTL
===============

# sd_data_rx

Receive side of the SD host DATA path: captures one data block sent by the card on the single-bit DAT0 line, packs it into 32-bit words for the host read FIFO, and checks CRC16 and the end bit. It pairs with the host's existing data transmit path and sits between the DAT0 pad logic and the read FIFO. It also reuses the same clock/reset domain as the structural counter blocks.

## Interface
Parameters:
- BLOCK_BYTES, 512, bytes per block; multiple of 4, minimum 4.
- TIMEOUT, 65535, cycles to wait for the start bit before aborting.

Ports:
- iCLK  in  1  clock; the card clock runs in the same domain, so iDAT is sampled on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iENB  in  1  one-cycle start request; honored only in IDLE.
- iDAT  in  1  DAT0 line from the card.
- iFIFO_FULL  in  1  read FIFO cannot accept a word.
- oFIFO_WR  out  1  write strobe to the FIFO.
- oFIFO_DATA  out  32  word to write; first received byte in [31:24].
- oCLK_STOP  out  1  request to gate the card clock; iDAT is ignored while high.
- oBUSY  out  1  high in any state other than IDLE.
- oDONE  out  1  one-cycle pulse at the end of the block.
- oCRC_ERR  out  1  received CRC does not match the computed CRC; held until the next accepted iENB.
- oEND_ERR  out  1  end bit was 0; held until the next accepted iENB.
- oTIMEOUT  out  1  one-cycle pulse when the start-bit wait expires.

## Operation
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT, FLUSH.
- IDLE -> WAIT_START on iENB. The same edge clears oCRC_ERR, oEND_ERR, the CRC register, and the timeout counter.
- WAIT_START: iDAT=0 -> DATA. Otherwise the counter increments; when the count reaches TIMEOUT, oTIMEOUT pulses and the FSM returns to IDLE with nothing written.
- DATA: shift in 8*BLOCK_BYTES bits, MSB first.
  - Each bit also feeds CRC16: x^16+x^12+x^5+1, initial value 0x0000.
  - Every 32nd bit loads the shift word into a holding register and sets hold_valid.
  - After the last data bit -> CRC.
- CRC: shift in 16 bits, MSB first, then compare with the computed CRC.
  - Mismatch sets oCRC_ERR; the FSM continues to ENDBIT either way.
- ENDBIT: sample one bit; a 0 sets oEND_ERR. -> FLUSH.
- FLUSH: wait until hold_valid=0, then pulse oDONE and go to IDLE.
- FIFO handshake:
  - oFIFO_WR = hold_valid & ~iFIFO_FULL; the FIFO captures oFIFO_DATA on that edge, which clears hold_valid.
  - oCLK_STOP = hold_valid & iFIFO_FULL. While it is high, no state advances and iDAT is not sampled.
  - The holding register is never overwritten while valid. The next word completes no earlier than 32 samples later, so one holding register is sufficient.
- iENB outside IDLE is ignored.
- Reset: all outputs 0, FSM to IDLE, hold_valid=0. A reset mid-block aborts the block with no further writes and no oDONE.

## Timing
- oFIFO_WR and oCLK_STOP are combinational from registered hold_valid and the iFIFO_FULL input. All other outputs are registered.
- Start bit sampled at edge S:
  - Data bit k (1-based) sampled at edge S+k.
  - First word valid after edge S+32; oFIFO_WR high in the following cycle if the FIFO is not full.
- With no stalls:
  - Last data bit at edge S+8*BLOCK_BYTES.
  - CRC bits at the next 16 edges.
  - End bit at edge S+8*BLOCK_BYTES+17.
  - oDONE high in the cycle after edge S+8*BLOCK_BYTES+18, i.e. one FLUSH cycle.
- Each stalled cycle (oCLK_STOP=1) delays every later event by exactly one cycle.
- oTIMEOUT is high in the cycle after edge TIMEOUT counted from WAIT_START entry.
- Simultaneous events:
  - A word completing on the same edge hold_valid clears is legal; the holding register reloads and stays valid.
  - iENB together with iReset: reset wins.

## Test plan
- BLOCK_BYTES=512, all data bytes 0xFF, CRC 0x7FA1, end bit 1, FIFO never full -> 128 writes of 0xFFFFFFFF, oCRC_ERR=0, oEND_ERR=0, oDONE pulses at S+4115.
- BLOCK_BYTES=4, data 0x12345678, correct CRC, end bit 1 -> one write of 0x12345678, first byte in [31:24], oDONE pulses, no error flags.
- BLOCK_BYTES=512, all 0xFF, CRC sent as 0x7FA0 -> oCRC_ERR=1 held after oDONE; a new iENB clears it.
- BLOCK_BYTES=4, all-zero data, CRC 0x0000, end bit 0 -> oEND_ERR=1, oCRC_ERR=0, write 0x00000000.
- BLOCK_BYTES=8, iFIFO_FULL high for 10 cycles when the first word completes -> oCLK_STOP high exactly 10 cycles, no bits lost, data correct, oDONE delayed by 10 cycles.
- TIMEOUT=20, iDAT held at 1 -> oTIMEOUT pulses after 20 cycles, no writes, FSM in IDLE. Separately, iReset mid-DATA -> outputs return to 0 and no further oFIFO_WR occurs.

Source files
------------

// File: rtl/sd_data_rx.sv
// SD host DAT0 receive path: captures one data block, packs it into 32-bit words
// for the read FIFO, and checks the CRC16 and the end bit.
module sd_data_rx #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 65535
) (
  input  logic        iCLK,
  input  logic        iReset,
  input  logic        iENB,
  input  logic        iDAT,
  input  logic        iFIFO_FULL,
  output logic        oFIFO_WR,
  output logic [31:0] oFIFO_DATA,
  output logic        oCLK_STOP,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oCRC_ERR,
  output logic        oEND_ERR,
  output logic        oTIMEOUT
);

  localparam int NBITS = 8 * BLOCK_BYTES;
  localparam int BW    = $clog2(NBITS);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_ENDBIT, S_FLUSH
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [3:0]      crc_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic [TW-1:0]   to_cnt_d;
  logic [31:0]     shift_q;
  logic [31:0]     shift_d;
  logic [31:0]     hold_q;
  logic            hold_valid_q;
  logic [15:0]     crc_q;
  logic [15:0]     crc_d;
  logic [15:0]     rx_crc_q;
  logic [15:0]     rx_crc_d;
  logic            busy_q;
  logic            done_q;
  logic            crc_err_q;
  logic            end_err_q;
  logic            timeout_q;
  logic            stall;
  logic            wr;

  // CRC16 x^16+x^12+x^5+1, one bit per call, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign stall    = hold_valid_q & iFIFO_FULL;
  assign wr       = hold_valid_q & ~iFIFO_FULL;
  assign shift_d  = {shift_q[30:0], iDAT};
  assign crc_d    = crc16_step(crc_q, iDAT);
  assign rx_crc_d = {rx_crc_q[14:0], iDAT};
  assign to_cnt_d = to_cnt_q + 1'b1;

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      to_cnt_q     <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      // A word completing on this edge below re-asserts hold_valid after the write clears it.
      if (wr) hold_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iENB) begin
            state_q   <= S_WAIT_START;
            busy_q    <= 1'b1;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            crc_q     <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            crc_cnt_q <= '0;
          end
        end
        S_WAIT_START: begin
          if (!iDAT) begin
            state_q <= S_DATA;
          end else begin
            to_cnt_q <= to_cnt_d;
            if (to_cnt_d == TW'(TIMEOUT)) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (!stall) begin
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q[4:0] == 5'd31) begin
              hold_q       <= shift_d;
              hold_valid_q <= 1'b1;
            end
            if (bit_cnt_q == BW'(NBITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (!stall) begin
            rx_crc_q  <= rx_crc_d;
            crc_cnt_q <= crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) begin
              if (rx_crc_d != crc_q) crc_err_q <= 1'b1;
              state_q <= S_ENDBIT;
            end
          end
        end
        S_ENDBIT: begin
          if (!stall) begin
            if (!iDAT) end_err_q <= 1'b1;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!hold_valid_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oFIFO_WR   = wr;
  assign oFIFO_DATA = hold_q;
  assign oCLK_STOP  = stall;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oCRC_ERR   = crc_err_q;
  assign oEND_ERR   = end_err_q;
  assign oTIMEOUT   = timeout_q;

endmodule
